// File: rtl/pipe_buffer_pkg.sv
// Shared geometry defaults for pipe_buffer and the count-width helper.
package pipe_buffer_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // count must represent 0..DEPTH inclusive, hence one bit more than a pointer
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pipe_buffer_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module pipe_buffer_mem
  import pipe_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_buffer.sv
// Valid/ready FIFO buffer; one-cycle push-to-out_valid latency, in_ready depends on count only.
// Define PIPE_BUFFER_ZERO_OUT_EN to force out_data to zero whenever out_valid is low.
module pipe_buffer
  import pipe_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             written;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  pipe_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // written masks the unreset array so out_data reads zero until the first push after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      written <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        written <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIPE_BUFFER_ZERO_OUT_EN
  assign out_data = out_valid ? head : '0;
`else
  assign out_data = written ? head : '0;
`endif
endmodule

// File: tb/tb_pipe_buffer.sv
// Self-checking bench: directed scenarios on the default geometry, random traffic on 8x2 and 32x16.
module tb_pipe_buffer;
  logic clk;
  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_count;

  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [4:0]  c_count;

  int checks = 0;
  int failures = 0;

  pipe_buffer u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count)
  );

  pipe_buffer #(.WIDTH(8), .DEPTH(2)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count)
  );

  pipe_buffer #(.WIDTH(32), .DEPTH(16)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .count(c_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    #12;
    reset = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #3;
    checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
    checks++; if (b_count !== 2'd0 || b_out_data !== 8'h0) begin failures++; $display("FAIL reset_b got=%0d/%h exp=0/0", b_count, b_out_data); end
    checks++; if (c_count !== 5'd0 || c_out_data !== 32'h0) begin failures++; $display("FAIL reset_c got=%0d/%h exp=0/0", c_count, c_out_data); end
    #10;
    reset = 1;
    step();
  endtask

  task automatic test_single_push();
    do_reset();
    a_in_valid = 1; a_in_data = 32'h11111111; a_out_ready = 0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL single_no_comb_path got=%b exp=0", a_out_valid); end
    step();
    a_in_valid = 0;
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", a_out_valid); end
    checks++; if (a_out_data !== 32'h11111111) begin failures++; $display("FAIL single_out_data got=%h exp=11111111", a_out_data); end
    checks++; if (a_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", a_count); end
  endtask

  task automatic test_full();
    do_reset();
    a_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_data = 32'hA0 + 32'(i);
      step();
    end
    checks++; if (a_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", a_count); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", a_in_ready); end
    a_in_data = 32'hA4;
    step();
    checks++; if (a_count !== 3'd4) begin failures++; $display("FAIL full_refused_count got=%0d exp=4", a_count); end
    checks++; if (a_out_data !== 32'hA0) begin failures++; $display("FAIL full_head got=%h exp=a0", a_out_data); end
    // pop while full: the simultaneous push must still be refused
    a_in_data = 32'hA5; a_out_ready = 1;
    step();
    a_in_valid = 0;
    checks++; if (a_count !== 3'd3) begin failures++; $display("FAIL full_pop_push_count got=%0d exp=3", a_count); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL full_drain_%0d got=%b/%h exp=1/%h", i, a_out_valid, a_out_data, 32'hA0 + 32'(i));
      end
      step();
    end
    checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%0d/%b exp=0/0", a_count, a_out_valid); end
    a_out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1; a_in_data = 32'hB0 + 32'(i);
      q.push_back(a_in_data);
      step();
    end
    a_out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      a_in_data = d;
      checks++;
      if (a_count !== 3'd2 || a_out_data !== q[0]) begin
        failures++; $display("FAIL b2b_%0d got=%0d/%h exp=2/%h", i, a_count, a_out_data, q[0]);
      end
      step();
      void'(q.pop_front());
      q.push_back(d);
    end
    a_in_valid = 0;
    checks++; if (a_count !== 3'd2) begin failures++; $display("FAIL b2b_final_count got=%0d exp=2", a_count); end
    while (q.size() > 0) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== q[0]) begin
        failures++; $display("FAIL b2b_drain got=%b/%h exp=1/%h", a_out_valid, a_out_data, q[0]);
      end
      step();
      void'(q.pop_front());
    end
    a_out_ready = 0;
  endtask

  task automatic test_flush();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_data = 32'hC0 + 32'(i);
      step();
    end
    a_flush = 1; a_in_valid = 1; a_in_data = 32'hCC; a_out_ready = 1;
    step();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
`ifdef PIPE_BUFFER_ZERO_OUT_EN
    exp = 32'h0;
`else
    exp = 32'hC0;
`endif
    checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", a_count); end
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_flags got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
    checks++; if (a_out_data !== exp) begin failures++; $display("FAIL flush_out_data got=%h exp=%h", a_out_data, exp); end
    a_in_valid = 1; a_in_data = 32'hD0;
    step();
    a_in_valid = 0;
    checks++; if (a_count !== 3'd1 || a_out_data !== 32'hD0) begin failures++; $display("FAIL flush_repush got=%0d/%h exp=1/d0", a_count, a_out_data); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_data = 32'hE0 + 32'(i);
      step();
    end
    checks++; if (a_count !== 3'd3) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=3", a_count); end
    a_in_data = 32'hEE; a_out_ready = 1;
    #2;
    reset = 0;
    #1;
    checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async got=%0d/%b exp=0/0", a_count, a_out_valid); end
    checks++; if (a_out_data !== 32'h0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_outputs got=%h/%b exp=0/1", a_out_data, a_in_ready); end
    step();
    checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL midrst_held got=%0d exp=0", a_count); end
    reset = 1; a_in_valid = 0; a_out_ready = 0;
    step();
    a_in_valid = 1; a_in_data = 32'h5A;
    step();
    a_in_valid = 0;
    checks++; if (a_out_data !== 32'h5A || a_count !== 3'd1) begin failures++; $display("FAIL midrst_repush got=%h/%0d exp=5a/1", a_out_data, a_count); end
  endtask

  task automatic test_random();
    logic [7:0]  qb[$];
    logic [31:0] qc[$];
    bit pb, pc, ob, oc;
    int phase;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++;
      if (b_count !== 2'(qb.size()) || b_out_valid !== (qb.size() != 0) || b_in_ready !== (qb.size() < 2) ||
          (qb.size() != 0 && b_out_data !== qb[0])) begin
        failures++;
        $display("FAIL rand_b cyc=%0d got cnt=%0d vld=%b rdy=%b dat=%h exp cnt=%0d head=%h",
                 cyc, b_count, b_out_valid, b_in_ready, b_out_data, qb.size(), (qb.size() != 0) ? qb[0] : 8'h0);
      end
      checks++;
      if (c_count !== 5'(qc.size()) || c_out_valid !== (qc.size() != 0) || c_in_ready !== (qc.size() < 16) ||
          (qc.size() != 0 && c_out_data !== qc[0])) begin
        failures++;
        $display("FAIL rand_c cyc=%0d got cnt=%0d vld=%b rdy=%b dat=%h exp cnt=%0d head=%h",
                 cyc, c_count, c_out_valid, c_in_ready, c_out_data, qc.size(), (qc.size() != 0) ? qc[0] : 32'h0);
      end
`ifdef PIPE_BUFFER_ZERO_OUT_EN
      checks++;
      if ((qb.size() == 0 && b_out_data !== 8'h0) || (qc.size() == 0 && c_out_data !== 32'h0)) begin
        failures++; $display("FAIL rand_zero_out cyc=%0d got=%h/%h exp=0/0", cyc, b_out_data, c_out_data);
      end
`endif
      phase = (cyc / 500) % 2;
      b_in_valid = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      b_out_ready = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c_in_valid = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      c_out_ready = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      b_in_data = 8'($urandom);
      c_in_data = $urandom;
      b_flush = ($urandom_range(0, 127) == 0);
      c_flush = ($urandom_range(0, 255) == 0);
      pb = b_in_valid && (qb.size() < 2);
      ob = b_out_ready && (qb.size() != 0);
      pc = c_in_valid && (qc.size() < 16);
      oc = c_out_ready && (qc.size() != 0);
      step();
      if (b_flush) qb.delete();
      else begin
        if (ob) void'(qb.pop_front());
        if (pb) qb.push_back(b_in_data);
      end
      if (c_flush) qc.delete();
      else begin
        if (oc) void'(qc.pop_front());
        if (pc) qc.push_back(c_in_data);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; legal values are 1 to 64.
REQ-002 Parameter DEPTH, default 4: number of storage entries; must be a power of two and at least 2.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all stored entries.
REQ-007 in_valid  input  1  producer presents a word.
REQ-008 in_ready  output  1  buffer can accept a word this cycle.
REQ-009 in_data  input  WIDTH  producer word.
REQ-010 out_valid  output  1  head word is available.
REQ-011 out_ready  input  1  consumer accepts the head word.
REQ-012 out_data  output  WIDTH  head word.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries, 0 to DEPTH.

Function
REQ-014 Push SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; pop SHALL occur when out_valid and out_ready are both 1.
REQ-015 The buffer SHALL be strict FIFO order; no word is lost or duplicated.
REQ-016 in_ready SHALL equal (count < DEPTH), decoded from registers only, and SHALL not depend on out_ready.
REQ-017 out_valid SHALL equal (count != 0), decoded from registers only.
REQ-018 out_data SHALL present the head entry; it is valid only while out_valid is 1.
REQ-019 Latency: a word pushed into an empty buffer SHALL appear with out_valid=1 on the cycle after the push edge; there is no combinational in->out path.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-021 When full, push is blocked by in_ready=0, even if a pop occurs in the same cycle.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 Flush=1 at an edge SHALL set count to 0, reset both pointers to 0, and discard any simultaneous push and pop.
REQ-024 Stored data is not cleared by flush; only pointer and count state change.

Reset
REQ-025 reset=0 SHALL asynchronously force count=0, both pointers=0, out_valid=0, in_ready=1, and out_data=0.
REQ-026 Storage contents after reset are don't-care, except that out_data reads 0 until the first push.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer; no push or pop completes on that edge.
REQ-028 Reset deassertion SHALL be usable asynchronously; the first push is accepted on the first edge after release.

Configuration
REQ-029 Macro PIPE_BUFFER_ZERO_OUT_EN: when defined, out_data SHALL be forced to all zeros whenever out_valid=0, including after flush and after the last pop.
REQ-030 Without PIPE_BUFFER_ZERO_OUT_EN, out_data SHALL be the raw head-entry value regardless of out_valid.

Structure
REQ-031 Shared package pipe_buffer_pkg SHALL hold the default WIDTH/DEPTH constants and a function for the count width.
REQ-032 Storage SHALL be a sub-module pipe_buffer_mem: DEPTH x WIDTH, one synchronous write port, one asynchronous read port, no reset on the array.
REQ-033 Pointers, count, handshake decode and the zero-out mux SHALL reside in pipe_buffer.

Verification
REQ-034 Reset then push 0x11111111 with out_ready=0: out_valid=1 on the next cycle, out_data=0x11111111, count=1.
REQ-035 Push 0xA0..0xA3 with out_ready=0 (DEPTH=4): count=4, in_ready=0; a fifth push with in_valid=1 is refused. Then drain with out_ready=1: outputs A0, A1, A2, A3 in order.
REQ-036 Continuous push/pop with count=2 for 10 cycles: count stays at 2, the output sequence matches the input, and pointers wrap at least twice.
REQ-037 Full buffer, flush=1 with in_valid=1 and out_ready=1: next cycle count=0, out_valid=0, in_ready=1. With PIPE_BUFFER_ZERO_OUT_EN defined, out_data=0.
REQ-038 Hold reset=0 for one cycle mid-stream at count=3: count=0 immediately (asynchronously) and out_data=0; after release, push 0x5A gives out_data=0x5A.
REQ-039 Random valid/ready for 10k cycles against a scoreboard, run with WIDTH=8, DEPTH=2 and with WIDTH=32, DEPTH=16: zero mismatches.
